axi_llc_evict_ctrl: RTL and testbench

Sequencing controller for the LLC eviction way-selection box. It round-robin arbitrates way-allocation requests from `NumPorts` miss paths, reads the tag state of the requested set, and holds the eviction box request until a way is picked. If no way becomes available within `MaxWait` cycles, it re-reads the tag state. It then emits one descriptor per request to the refill/write-back stage. It sits between the hit/miss detection front end and the eviction box plus the downstream miss pipeline.

---
 rtl/axi_llc_evict_ctrl.sv | 179 +++++++++++++++++
 tb/tb_axi_llc_evict_ctrl.sv | 463 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_llc_evict_ctrl.sv
// LLC eviction sequencer. It arbitrates the miss ports, reads the tag state and
// drives the eviction box until a way is picked, then emits one refill descriptor.
package axi_llc_evict_pkg;
  typedef struct packed {
    int unsigned SetAssociativity;
    int unsigned IndexLength;
  } cfg_t;
endpackage

module axi_llc_evict_ctrl
  import axi_llc_evict_pkg::*;
#(
  parameter cfg_t         Cfg       = '{default: '0},
  parameter type          way_ind_t = logic,
  parameter int unsigned  NumPorts  = 2,
  parameter int unsigned  MaxWait   = 16,
  localparam int unsigned IdxW      = (Cfg.IndexLength == 0) ? 1 : Cfg.IndexLength,
  localparam int unsigned PortW     = (NumPorts > 1) ? $clog2(NumPorts) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NumPorts-1:0]      req_valid_i,
  input  logic [NumPorts*IdxW-1:0] req_index_i,
  output logic [NumPorts-1:0]      req_ready_o,
  output logic                     tag_req_o,
  output logic [IdxW-1:0]          tag_index_o,
  input  logic                     tag_gnt_i,
  input  logic                     tag_rvalid_i,
  input  way_ind_t                 tag_valid_i,
  input  way_ind_t                 tag_dirty_i,
  input  way_ind_t                 tag_cmpt_i,
  output logic                     box_req_o,
  output way_ind_t                 box_valid_o,
  output way_ind_t                 box_dirty_o,
  output way_ind_t                 box_cmpt_o,
  input  way_ind_t                 box_way_i,
  input  logic                     box_evict_i,
  input  logic                     box_valid_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [PortW-1:0]         out_port_o,
  output logic [IdxW-1:0]          out_index_o,
  output way_ind_t                 out_way_o,
  output logic                     out_evict_o,
  output logic [15:0]              retry_cnt_o
);

  localparam int unsigned      WaitW    = $clog2(MaxWait);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(MaxWait - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    TAG_REQ  = 3'd1,
    TAG_WAIT = 3'd2,
    PICK     = 3'd3,
    OUT      = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [PortW-1:0] rr_q, port_q, grant_port, rr_next;
  logic [IdxW-1:0]  index_q, grant_index;
  logic             grant_found;
  logic [WaitW-1:0] wait_q;
  logic             wait_done;

  // Round-robin: first valid port at or above rr_q, otherwise wrap to the lowest one.
  always_comb begin
    grant_found = 1'b0;
    grant_port  = '0;
    grant_index = '0;
    for (int unsigned i = 0; i < NumPorts; i++) begin
      if (!grant_found && (i >= 32'(rr_q)) && req_valid_i[i]) begin
        grant_found = 1'b1;
        grant_port  = PortW'(i);
        grant_index = req_index_i[i*IdxW +: IdxW];
      end
    end
    for (int unsigned i = 0; i < NumPorts; i++) begin
      if (!grant_found && req_valid_i[i]) begin
        grant_found = 1'b1;
        grant_port  = PortW'(i);
        grant_index = req_index_i[i*IdxW +: IdxW];
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    if ((state_q == IDLE) && grant_found) begin
      req_ready_o[grant_port] = 1'b1;
    end
  end

  assign wait_done = (wait_q == WaitLast);
  assign rr_next   = (32'(port_q) == NumPorts - 1) ? '0 : port_q + PortW'(1);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (grant_found)  state_d = TAG_REQ;
      TAG_REQ:  if (tag_gnt_i)    state_d = TAG_WAIT;
      TAG_WAIT: if (tag_rvalid_i) state_d = PICK;
      PICK: begin
        if (box_valid_i)    state_d = OUT;
        else if (wait_done) state_d = TAG_REQ;
      end
      OUT:      if (out_ready_i)  state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request context, tag snapshot and box decision; each loads only on its state edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q        <= '0;
      port_q      <= '0;
      index_q     <= '0;
      wait_q      <= '0;
      retry_cnt_o <= '0;
      box_valid_o <= '0;
      box_dirty_o <= '0;
      box_cmpt_o  <= '0;
      out_way_o   <= '0;
      out_evict_o <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_found) begin
            port_q  <= grant_port;
            index_q <= grant_index;
          end
        end
        TAG_WAIT: begin
          if (tag_rvalid_i) begin
            box_valid_o <= tag_valid_i;
            box_dirty_o <= tag_dirty_i;
            box_cmpt_o  <= tag_cmpt_i;
            wait_q      <= '0;
          end
        end
        PICK: begin
          if (box_valid_i) begin
            out_way_o   <= box_way_i;
            out_evict_o <= box_evict_i;
          end else if (wait_done) begin
            wait_q <= '0;
            if (retry_cnt_o != 16'hFFFF) begin
              retry_cnt_o <= retry_cnt_o + 16'd1;
            end
          end else begin
            wait_q <= wait_q + WaitW'(1);
          end
        end
        OUT: begin
          if (out_ready_i) begin
            rr_q <= rr_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign tag_req_o   = (state_q == TAG_REQ);
  assign box_req_o   = (state_q == PICK);
  assign out_valid_o = (state_q == OUT);
  assign tag_index_o = index_q;
  assign out_index_o = index_q;
  assign out_port_o  = port_q;

endmodule

// File: tb/tb_axi_llc_evict_ctrl.sv
// Scenario bench for axi_llc_evict_ctrl: 2 ports, 4 ways, 8-bit index, MaxWait=4.
// Expected descriptors are queued at grant time and popped when out_valid_o shows.
module tb_axi_llc_evict_ctrl;
  import axi_llc_evict_pkg::*;

  localparam cfg_t TbCfg = '{SetAssociativity: 32'd4, IndexLength: 32'd8};

  typedef struct {
    logic [0:0] port;
    logic [7:0] index;
    logic [3:0] way;
    logic       evict;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   rr_m = 0;
  int   retry_m = 0;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [1:0]  req_valid_i = '0;
  logic [15:0] req_index_i = '0;
  logic [1:0]  req_ready_o;
  logic        tag_req_o;
  logic [7:0]  tag_index_o;
  logic        tag_gnt_i = 1'b0;
  logic        tag_rvalid_i = 1'b0;
  logic [3:0]  tag_valid_i = '0;
  logic [3:0]  tag_dirty_i = '0;
  logic [3:0]  tag_cmpt_i = '0;
  logic        box_req_o;
  logic [3:0]  box_valid_o, box_dirty_o, box_cmpt_o;
  logic [3:0]  box_way_i = '0;
  logic        box_evict_i = 1'b0;
  logic        box_valid_i = 1'b0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [0:0]  out_port_o;
  logic [7:0]  out_index_o;
  logic [3:0]  out_way_o;
  logic        out_evict_o;
  logic [15:0] retry_cnt_o;

  axi_llc_evict_ctrl #(
    .Cfg       (TbCfg),
    .way_ind_t (logic [3:0]),
    .NumPorts  (2),
    .MaxWait   (4)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req_valid_i  (req_valid_i),
    .req_index_i  (req_index_i),
    .req_ready_o  (req_ready_o),
    .tag_req_o    (tag_req_o),
    .tag_index_o  (tag_index_o),
    .tag_gnt_i    (tag_gnt_i),
    .tag_rvalid_i (tag_rvalid_i),
    .tag_valid_i  (tag_valid_i),
    .tag_dirty_i  (tag_dirty_i),
    .tag_cmpt_i   (tag_cmpt_i),
    .box_req_o    (box_req_o),
    .box_valid_o  (box_valid_o),
    .box_dirty_o  (box_dirty_o),
    .box_cmpt_o   (box_cmpt_o),
    .box_way_i    (box_way_i),
    .box_evict_i  (box_evict_i),
    .box_valid_i  (box_valid_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .out_port_o   (out_port_o),
    .out_index_o  (out_index_o),
    .out_way_o    (out_way_o),
    .out_evict_o  (out_evict_o),
    .retry_cnt_o  (retry_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Called on the TAG_REQ negedge; returns on the first PICK negedge.
  task automatic tag_phase(input logic [3:0] tv, input logic [3:0] td, input logic [3:0] tc);
    tag_gnt_i = 1'b1;
    @(negedge clk_i);
    tag_gnt_i    = 1'b0;
    tag_rvalid_i = 1'b1;
    tag_valid_i  = tv;
    tag_dirty_i  = td;
    tag_cmpt_i   = tc;
    @(negedge clk_i);
    tag_rvalid_i = 1'b0;
    tag_valid_i  = 4'hF;
    tag_dirty_i  = 4'hF;
    tag_cmpt_i   = 4'hF;
  endtask

  // Called on a PICK negedge; returns just after the first OUT negedge.
  task automatic box_phase(input logic [3:0] way, input logic ev);
    box_valid_i = 1'b1;
    box_way_i   = way;
    box_evict_i = ev;
    @(negedge clk_i);
    box_valid_i = 1'b0;
    box_way_i   = 4'b0000;
    box_evict_i = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    #1;
    n_cmp++;
    if ({req_ready_o, tag_req_o, tag_index_o, box_req_o, box_valid_o, box_dirty_o, box_cmpt_o,
         out_valid_o, out_port_o, out_index_o, out_way_o, out_evict_o, retry_cnt_o} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got rdy=%b treq=%b breq=%b ov=%b retry=%h want all zero",
               req_ready_o, tag_req_o, box_req_o, out_valid_o, retry_cnt_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    n_cmp++;
    if ({req_ready_o, tag_req_o, box_req_o, out_valid_o} !== 5'b0) begin
      n_bad++;
      $display("FAIL idle_after_reset: got rdy=%b treq=%b breq=%b ov=%b want 0",
               req_ready_o, tag_req_o, box_req_o, out_valid_o);
    end
  endtask

  task automatic test_single();
    exp_t e;
    @(negedge clk_i);
    req_valid_i = 2'b01;
    req_index_i = {8'h00, 8'h12};
    #1;
    n_cmp++;
    if (req_ready_o !== 2'b01) begin
      n_bad++; $display("FAIL single_grant: got %b want 01", req_ready_o);
    end
    sb.push_back('{port: 1'b0, index: 8'h12, way: 4'b0100, evict: 1'b0});
    @(negedge clk_i);
    req_valid_i = 2'b00;
    #1;
    n_cmp++;
    if ({tag_req_o, tag_index_o} !== {1'b1, 8'h12}) begin
      n_bad++; $display("FAIL single_tag_req: got req=%b idx=%h want 1 12", tag_req_o, tag_index_o);
    end
    tag_phase(4'b0011, 4'b0000, 4'b0001);
    #1;
    n_cmp++;
    if ({box_req_o, box_valid_o, box_dirty_o, box_cmpt_o, out_valid_o} !== {1'b1, 4'b0011, 4'b0000, 4'b0001, 1'b0}) begin
      n_bad++;
      $display("FAIL single_pick: got breq=%b v=%b d=%b c=%b ov=%b want 1 0011 0000 0001 0",
               box_req_o, box_valid_o, box_dirty_o, box_cmpt_o, out_valid_o);
    end
    box_phase(4'b0100, 1'b0);
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++; $display("FAIL single_desc: got out_valid=%b with empty scoreboard", out_valid_o);
    end else begin
      e = sb.pop_front();
      if (out_valid_o !== 1'b1 || {out_port_o, out_index_o, out_way_o, out_evict_o} !== {e.port, e.index, e.way, e.evict}) begin
        n_bad++;
        $display("FAIL single_desc: got v=%b p=%0d i=%h w=%b e=%b want v=1 p=%0d i=%h w=%b e=%b",
                 out_valid_o, out_port_o, out_index_o, out_way_o, out_evict_o, e.port, e.index, e.way, e.evict);
      end
    end
    out_ready_i = 1'b1;
    @(negedge clk_i);
    out_ready_i = 1'b0;
    rr_m = 1;
    #1;
    n_cmp++;
    if (out_valid_o !== 1'b0) begin
      n_bad++; $display("FAIL single_release: got out_valid=%b want 0", out_valid_o);
    end
  endtask

  task automatic test_round_robin();
    exp_t e;
    logic [7:0] idx [2];
    idx[0] = 8'h20;
    idx[1] = 8'h31;
    @(negedge clk_i);
    req_index_i = {idx[1], idx[0]};
    req_valid_i = 2'b11;
    #1;
    for (int t = 0; t < 3; t++) begin
      int ep;
      ep = rr_m;
      n_cmp++;
      if (req_ready_o !== 2'(1 << ep)) begin
        n_bad++; $display("FAIL rr_grant%0d: got %b want port %0d only", t, req_ready_o, ep);
      end
      sb.push_back('{port: 1'(ep), index: idx[ep], way: 4'(1 << t), evict: 1'b0});
      @(negedge clk_i);
      #1;
      n_cmp++;
      if (req_ready_o !== 2'b00) begin
        n_bad++; $display("FAIL rr_busy_ready%0d: got %b want 00", t, req_ready_o);
      end
      tag_phase(4'b1111, 4'b0000, 4'b0000);
      box_phase(4'(1 << t), 1'b0);
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++; $display("FAIL rr_desc%0d: got out_valid=%b with empty scoreboard", t, out_valid_o);
      end else begin
        e = sb.pop_front();
        if (out_valid_o !== 1'b1 || {out_port_o, out_index_o, out_way_o, out_evict_o} !== {e.port, e.index, e.way, e.evict}) begin
          n_bad++;
          $display("FAIL rr_desc%0d: got v=%b p=%0d i=%h w=%b e=%b want v=1 p=%0d i=%h w=%b e=%b", t,
                   out_valid_o, out_port_o, out_index_o, out_way_o, out_evict_o, e.port, e.index, e.way, e.evict);
        end
      end
      out_ready_i = 1'b1;
      @(negedge clk_i);
      out_ready_i = 1'b0;
      rr_m = (ep + 1) % 2;
      #1;
    end
    req_valid_i = 2'b00;
  endtask

  task automatic test_retry();
    exp_t e;
    @(negedge clk_i);
    req_valid_i = 2'b01;
    req_index_i = {8'h00, 8'h5A};
    #1;
    n_cmp++;
    if (req_ready_o !== 2'b01) begin
      n_bad++; $display("FAIL retry_grant: got %b want 01", req_ready_o);
    end
    sb.push_back('{port: 1'b0, index: 8'h5A, way: 4'b0010, evict: 1'b0});
    @(negedge clk_i);
    req_valid_i = 2'b00;
    tag_phase(4'b0001, 4'b0000, 4'b0000);
    for (int k = 0; k < 4; k++) begin
      #1;
      n_cmp++;
      if ({box_req_o, tag_req_o, retry_cnt_o} !== {1'b1, 1'b0, 16'(retry_m)}) begin
        n_bad++;
        $display("FAIL retry_pick%0d: got breq=%b treq=%b retry=%0d want 1 0 %0d", k, box_req_o, tag_req_o, retry_cnt_o, retry_m);
      end
      @(negedge clk_i);
    end
    retry_m++;
    #1;
    n_cmp++;
    if ({tag_req_o, box_req_o, tag_index_o, retry_cnt_o} !== {1'b1, 1'b0, 8'h5A, 16'(retry_m)}) begin
      n_bad++;
      $display("FAIL retry_reread: got treq=%b breq=%b idx=%h retry=%0d want 1 0 5a %0d",
               tag_req_o, box_req_o, tag_index_o, retry_cnt_o, retry_m);
    end
    tag_phase(4'b0111, 4'b0010, 4'b0000);
    #1;
    n_cmp++;
    if ({box_valid_o, box_dirty_o} !== {4'b0111, 4'b0010}) begin
      n_bad++; $display("FAIL retry_new_tags: got v=%b d=%b want 0111 0010", box_valid_o, box_dirty_o);
    end
    box_phase(4'b0010, 1'b0);
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++; $display("FAIL retry_desc: got out_valid=%b with empty scoreboard", out_valid_o);
    end else begin
      e = sb.pop_front();
      if (out_valid_o !== 1'b1 || {out_port_o, out_index_o, out_way_o, out_evict_o} !== {e.port, e.index, e.way, e.evict}) begin
        n_bad++;
        $display("FAIL retry_desc: got v=%b p=%0d i=%h w=%b e=%b want v=1 p=%0d i=%h w=%b e=%b",
                 out_valid_o, out_port_o, out_index_o, out_way_o, out_evict_o, e.port, e.index, e.way, e.evict);
      end
    end
    out_ready_i = 1'b1;
    @(negedge clk_i);
    out_ready_i = 1'b0;
    rr_m = 1;
    #1;
  endtask

  task automatic test_backpressure();
    exp_t e;
    exp_t held;
    logic [7:0] idx [2];
    int ep;
    idx[0] = 8'h33;
    idx[1] = 8'h44;
    @(negedge clk_i);
    req_index_i = {idx[1], idx[0]};
    req_valid_i = 2'b11;
    #1;
    ep = rr_m;
    n_cmp++;
    if (req_ready_o !== 2'(1 << ep)) begin
      n_bad++; $display("FAIL bp_grant: got %b want port %0d only", req_ready_o, ep);
    end
    sb.push_back('{port: 1'(ep), index: idx[ep], way: 4'b0001, evict: 1'b1});
    @(negedge clk_i);
    tag_phase(4'b1111, 4'b0001, 4'b0000);
    box_phase(4'b0001, 1'b1);
    held = '{port: 1'b0, index: 8'h00, way: 4'b0000, evict: 1'b0};
    if (sb.size() != 0) held = sb.pop_front();
    for (int c = 0; c < 10; c++) begin
      n_cmp++;
      if (out_valid_o !== 1'b1 || req_ready_o !== 2'b00 ||
          {out_port_o, out_index_o, out_way_o, out_evict_o} !== {held.port, held.index, held.way, held.evict}) begin
        n_bad++;
        $display("FAIL bp_hold%0d: got v=%b rdy=%b p=%0d i=%h w=%b e=%b want v=1 rdy=00 p=%0d i=%h w=%b e=%b", c,
                 out_valid_o, req_ready_o, out_port_o, out_index_o, out_way_o, out_evict_o,
                 held.port, held.index, held.way, held.evict);
      end
      @(negedge clk_i);
      #1;
    end
    out_ready_i = 1'b1;
    @(negedge clk_i);
    out_ready_i = 1'b0;
    rr_m = (ep + 1) % 2;
    ep = rr_m;
    #1;
    n_cmp++;
    if ({out_valid_o, req_ready_o} !== {1'b0, 2'(1 << ep)}) begin
      n_bad++; $display("FAIL bp_resume: got ov=%b rdy=%b want 0 and port %0d only", out_valid_o, req_ready_o, ep);
    end
    sb.push_back('{port: 1'(ep), index: idx[ep], way: 4'b0010, evict: 1'b0});
    @(negedge clk_i);
    req_valid_i = 2'b00;
    tag_phase(4'b1111, 4'b0000, 4'b0000);
    box_phase(4'b0010, 1'b0);
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++; $display("FAIL bp_desc: got out_valid=%b with empty scoreboard", out_valid_o);
    end else begin
      e = sb.pop_front();
      if (out_valid_o !== 1'b1 || {out_port_o, out_index_o, out_way_o, out_evict_o} !== {e.port, e.index, e.way, e.evict}) begin
        n_bad++;
        $display("FAIL bp_desc: got v=%b p=%0d i=%h w=%b e=%b want v=1 p=%0d i=%h w=%b e=%b",
                 out_valid_o, out_port_o, out_index_o, out_way_o, out_evict_o, e.port, e.index, e.way, e.evict);
      end
    end
    out_ready_i = 1'b1;
    @(negedge clk_i);
    out_ready_i = 1'b0;
    rr_m = (ep + 1) % 2;
    #1;
  endtask

  task automatic test_dirty_evict();
    exp_t e;
    @(negedge clk_i);
    req_valid_i = 2'b01;
    req_index_i = {8'h00, 8'h7E};
    #1;
    n_cmp++;
    if (req_ready_o !== 2'b01) begin
      n_bad++; $display("FAIL dirty_grant: got %b want 01", req_ready_o);
    end
    sb.push_back('{port: 1'b0, index: 8'h7E, way: 4'b1000, evict: 1'b1});
    @(negedge clk_i);
    req_valid_i = 2'b00;
    tag_phase(4'b1111, 4'b1000, 4'b0000);
    #1;
    n_cmp++;
    if ({box_valid_o, box_dirty_o} !== {4'b1111, 4'b1000}) begin
      n_bad++; $display("FAIL dirty_tags: got v=%b d=%b want 1111 1000", box_valid_o, box_dirty_o);
    end
    box_phase(4'b1000, 1'b1);
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++; $display("FAIL dirty_desc: got out_valid=%b with empty scoreboard", out_valid_o);
    end else begin
      e = sb.pop_front();
      if (out_valid_o !== 1'b1 || {out_port_o, out_index_o, out_way_o, out_evict_o} !== {e.port, e.index, e.way, e.evict}) begin
        n_bad++;
        $display("FAIL dirty_desc: got v=%b p=%0d i=%h w=%b e=%b want v=1 p=%0d i=%h w=%b e=%b",
                 out_valid_o, out_port_o, out_index_o, out_way_o, out_evict_o, e.port, e.index, e.way, e.evict);
      end
    end
    out_ready_i = 1'b1;
    @(negedge clk_i);
    out_ready_i = 1'b0;
    rr_m = 1;
    #1;
  endtask

  task automatic test_reset_mid_pick();
    exp_t e;
    @(negedge clk_i);
    req_valid_i = 2'b01;
    req_index_i = {8'h00, 8'h66};
    #1;
    n_cmp++;
    if (req_ready_o !== 2'b01) begin
      n_bad++; $display("FAIL rst_grant: got %b want 01", req_ready_o);
    end
    @(negedge clk_i);
    req_valid_i = 2'b00;
    tag_phase(4'b1111, 4'b0100, 4'b0010);
    #1;
    n_cmp++;
    if (box_req_o !== 1'b1) begin
      n_bad++; $display("FAIL rst_in_pick: got box_req=%b want 1", box_req_o);
    end
    rst_ni = 1'b0;
    #1;
    n_cmp++;
    if ({req_ready_o, tag_req_o, tag_index_o, box_req_o, box_valid_o, box_dirty_o, box_cmpt_o,
         out_valid_o, out_port_o, out_index_o, out_way_o, out_evict_o, retry_cnt_o} !== '0) begin
      n_bad++;
      $display("FAIL rst_mid_pick: got breq=%b bv=%b w=%b i=%h retry=%0d want all zero",
               box_req_o, box_valid_o, out_way_o, out_index_o, retry_cnt_o);
    end
    @(negedge clk_i);
    rst_ni  = 1'b1;
    rr_m    = 0;
    retry_m = 0;
    @(negedge clk_i);
    req_valid_i = 2'b11;
    req_index_i = {8'h99, 8'h88};
    #1;
    n_cmp++;
    if (req_ready_o !== 2'b01) begin
      n_bad++; $display("FAIL rst_rr_cleared: got %b want 01", req_ready_o);
    end
    sb.push_back('{port: 1'b0, index: 8'h88, way: 4'b0001, evict: 1'b0});
    @(negedge clk_i);
    req_valid_i = 2'b00;
    tag_phase(4'b0000, 4'b0000, 4'b0000);
    box_phase(4'b0001, 1'b0);
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++; $display("FAIL rst_after_desc: got out_valid=%b with empty scoreboard", out_valid_o);
    end else begin
      e = sb.pop_front();
      if (out_valid_o !== 1'b1 || retry_cnt_o !== 16'(retry_m) ||
          {out_port_o, out_index_o, out_way_o, out_evict_o} !== {e.port, e.index, e.way, e.evict}) begin
        n_bad++;
        $display("FAIL rst_after_desc: got v=%b p=%0d i=%h w=%b e=%b r=%0d want v=1 p=%0d i=%h w=%b e=%b r=%0d",
                 out_valid_o, out_port_o, out_index_o, out_way_o, out_evict_o, retry_cnt_o,
                 e.port, e.index, e.way, e.evict, retry_m);
      end
    end
    out_ready_i = 1'b1;
    @(negedge clk_i);
    out_ready_i = 1'b0;
    rr_m = 1;
    #1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_retry();
    test_backpressure();
    test_dirty_evict();
    test_reset_mid_pick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
